// File: rtl/kgp_pkg.sv
// Purpose: shared encodings for the KGP-RISC sequencer (states, op classes, branch conditions, flag bits).
// Latency: none, constants and types only.
// Backpressure: not applicable.
package kgp_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALTED = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  // Decoded instruction classes; 5 and 6 are reserved and execute as NOP.
  localparam logic [2:0] OP_ALU    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_JUMP   = 3'd4;
  localparam logic [2:0] OP_HALT   = 3'd7;

  // Branch condition codes.
  localparam logic [2:0] BR_ALWAYS = 3'd0;
  localparam logic [2:0] BR_BZ     = 3'd1;
  localparam logic [2:0] BR_BNZ    = 3'd2;
  localparam logic [2:0] BR_BCY    = 3'd3;
  localparam logic [2:0] BR_BNCY   = 3'd4;
  localparam logic [2:0] BR_BPL    = 3'd5;
  localparam logic [2:0] BR_BMI    = 3'd6;
  localparam logic [2:0] BR_NEVER  = 3'd7;

  // Bit positions inside the {carry, zero, sign} flag vector.
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_SIGN  = 0;

endpackage

// File: rtl/kgp_branch_eval.sv
// Purpose: resolve a branch condition against the stored flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none, output follows inputs.
module kgp_branch_eval
  import kgp_pkg::*;
(
  input  logic [2:0] i_flags,
  input  logic [2:0] i_cond,
  output logic       o_taken
);

  // Map each condition code onto the relevant flag bit or constant.
  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      BR_ALWAYS: o_taken = 1'b1;
      BR_BZ:     o_taken = i_flags[FLAG_ZERO];
      BR_BNZ:    o_taken = ~i_flags[FLAG_ZERO];
      BR_BCY:    o_taken = i_flags[FLAG_CARRY];
      BR_BNCY:   o_taken = ~i_flags[FLAG_CARRY];
      BR_BPL:    o_taken = ~i_flags[FLAG_SIGN];
      BR_BMI:    o_taken = i_flags[FLAG_SIGN];
      BR_NEVER:  o_taken = 1'b0;
      default:   o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/kgp_seq_ctrl.sv
// Purpose: multi-cycle FETCH/DECODE/EXEC/MEM sequencer owning the condition flags and retire counter.
// Latency: 3 cycles for ALU/BRANCH/JUMP, 4 for LOAD/STORE with zero-wait memory.
// Backpressure: FETCH and MEM stall on mem_ready=0, bounded by MEM_TIMEOUT before trapping to FAULT.
module kgp_seq_ctrl
  import kgp_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op_class,
  input  logic [2:0]       br_cond,
  input  logic             set_flags,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_sign,
  input  logic             mem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             rf_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic [2:0]       flags,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int              WAIT_W    = 16;
  // The wait counter value in the last allowed stall cycle; one more miss traps.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t             r_state;
  logic [2:0]         r_op;
  logic [2:0]         r_cond;
  logic               r_setf;
  logic [2:0]         r_flags;
  logic [WAIT_W-1:0]  r_wait;
  logic [CNT_W-1:0]   r_count;

  logic w_taken;
  logic w_timeout;
  logic w_halt_entry;
  logic w_ir_we;
  logic w_pc_we;
  logic w_pc_sel;
  logic w_rf_we;
  logic w_mem_req;
  logic w_mem_we;

  kgp_branch_eval u_branch_eval (
    .i_flags (r_flags),
    .i_cond  (r_cond),
    .o_taken (w_taken)
  );

  // A stall cycle that would push the wait count to the limit traps; ready in that cycle still wins.
  assign w_timeout    = (MEM_TIMEOUT != 0) && !mem_ready && (r_wait == WAIT_LAST);
  assign w_halt_entry = (r_state == S_EXEC) && (r_op == OP_HALT);

  // Enables decode from state; ready-dependent strobes react in the same cycle as mem_ready.
  always_comb begin
    w_ir_we   = 1'b0;
    w_pc_we   = 1'b0;
    w_pc_sel  = 1'b0;
    w_rf_we   = 1'b0;
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_ir_we   = mem_ready;
      end
      S_EXEC: begin
        case (r_op)
          OP_ALU: begin
            w_rf_we = 1'b1;
            w_pc_we = 1'b1;
          end
          OP_BRANCH: begin
            w_pc_we  = 1'b1;
            w_pc_sel = w_taken;
          end
          OP_JUMP: begin
            w_pc_we  = 1'b1;
            w_pc_sel = 1'b1;
          end
          OP_LOAD, OP_STORE, OP_HALT: begin
            w_pc_we = 1'b0;
          end
          default: begin
            w_pc_we = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (r_op == OP_STORE);
        if (mem_ready) begin
          w_pc_we = 1'b1;
          w_rf_we = (r_op == OP_LOAD);
        end
      end
      default: begin
        w_mem_req = 1'b0;
      end
    endcase
  end

  // Sequencer state, decode latches, flags and memory wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_cond  <= '0;
      r_setf  <= 1'b0;
      r_flags <= '0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wait <= '0;
          if (start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_state <= S_FAULT;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          r_wait  <= '0;
          r_op    <= op_class;
          r_cond  <= br_cond;
          r_setf  <= set_flags;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_wait <= '0;
          case (r_op)
            OP_ALU: begin
              if (r_setf) r_flags <= {alu_carry, alu_zero, alu_sign};
              r_state <= S_FETCH;
            end
            OP_LOAD, OP_STORE: r_state <= S_MEM;
            OP_HALT:           r_state <= S_HALTED;
            default:           r_state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            r_wait  <= '0;
            r_state <= S_FETCH;
          end else if (w_timeout) begin
            r_state <= S_FAULT;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_HALTED, S_FAULT: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= S_FAULT;
        end
      endcase
    end
  end

  // Retire counter: one count per PC update and one for the HALT itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_pc_we || w_halt_entry) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign ir_we       = w_ir_we;
  assign pc_we       = w_pc_we;
  assign pc_sel      = w_pc_sel;
  assign rf_we       = w_rf_we;
  assign mem_req     = w_mem_req;
  assign mem_we      = w_mem_we;
  assign flags       = r_flags;
  assign state       = r_state;
  assign halted      = (r_state == S_HALTED);
  assign fault       = (r_state == S_FAULT);
  assign instr_count = r_count;

endmodule

// File: tb/tb_kgp_seq_ctrl.sv
// Purpose: directed self-checking bench for the KGP-RISC sequencer.
// Latency: inputs change just after the falling edge, outputs are checked 1ns later.
// Backpressure: mem_ready is driven per scenario to exercise stalls and timeouts.
module tb_kgp_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op_class;
  logic [2:0]  br_cond;
  logic        set_flags;
  logic        alu_carry, alu_zero, alu_sign;
  logic        mem_ready;
  logic        ir_we, pc_we, pc_sel, rf_we, mem_req, mem_we;
  logic [2:0]  flags;
  logic [2:0]  state;
  logic        halted, fault;
  logic [15:0] instr_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  kgp_seq_ctrl #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .op_class(op_class), .br_cond(br_cond),
    .set_flags(set_flags), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .mem_req(mem_req), .mem_we(mem_we), .flags(flags), .state(state), .halted(halted),
    .fault(fault), .instr_count(instr_count)
  );

  // Advance to the next cycle's check point.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; set_flags = 1'b0;
    op_class = 3'd0; br_cond = 3'd0; {alu_carry, alu_zero, alu_sign} = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_cnt = 16'd0;
  endtask

  // From IDLE, start and land in the first FETCH cycle.
  task automatic start_run();
    start = 1'b1;
    #1;
    nxt();
    start = 1'b0;
    #1;
  endtask

  // From a FETCH cycle with zero-wait memory, return positioned in EXEC.
  task automatic go_exec(input logic [2:0] op, input logic [2:0] cond, input logic sf);
    op_class = op; br_cond = cond; set_flags = sf; mem_ready = 1'b1;
    #1;
    nxt();
    nxt();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++;
    if ({ir_we, pc_we, pc_sel, rf_we, mem_req, mem_we, halted, fault} !== 8'h00) begin
      errors++; $display("FAIL reset_enables got=%b exp=00000000",
                        {ir_we, pc_we, pc_sel, rf_we, mem_req, mem_we, halted, fault});
    end
    checks++;
    if ({flags, instr_count} !== 19'd0) begin
      errors++; $display("FAIL reset_flags_cnt flags=%b cnt=%0d exp 0/0", flags, instr_count);
    end
  endtask

  task automatic test_alu();
    do_reset();
    start = 1'b1; mem_ready = 1'b1; op_class = 3'd0; set_flags = 1'b1;
    {alu_carry, alu_zero, alu_sign} = 3'b101;
    #1;
    nxt(); start = 1'b0; #1;
    checks++;
    if ({state, ir_we, mem_req} !== {3'd1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL alu_fetch state=%0d ir_we=%b mem_req=%b exp 1/1/1", state, ir_we, mem_req);
    end
    nxt();
    checks++;
    if ({state, ir_we, pc_we, rf_we, mem_req} !== {3'd2, 4'b0000}) begin
      errors++; $display("FAIL alu_decode state=%0d en=%b exp 2/0000", state, {ir_we, pc_we, rf_we, mem_req});
    end
    nxt();
    checks++;
    if ({state, rf_we, pc_we, pc_sel, flags} !== {3'd3, 3'b110, 3'b000}) begin
      errors++; $display("FAIL alu_exec state=%0d rf/pc/sel=%b flags=%b exp 3/110/000",
                        state, {rf_we, pc_we, pc_sel}, flags);
    end
    nxt();
    exp_cnt = 16'd1;
    checks++;
    if ({state, flags, instr_count} !== {3'd1, 3'b101, exp_cnt}) begin
      errors++; $display("FAIL alu_after state=%0d flags=%b cnt=%0d exp 1/101/%0d",
                        state, flags, instr_count, exp_cnt);
    end
  endtask

  // Run all eight conditions against two flag patterns; distractor ALU inputs must not leak in.
  task automatic test_branch();
    logic [2:0] fl;
    logic [7:0] tk;
    for (int p = 0; p < 2; p++) begin
      fl = (p == 0) ? 3'b010 : 3'b101;
      tk = (p == 0) ? 8'b0011_0011 : 8'b0100_1101;
      {alu_carry, alu_zero, alu_sign} = fl;
      go_exec(3'd0, 3'd0, 1'b1);
      nxt(); exp_cnt = exp_cnt + 16'd1;
      {alu_carry, alu_zero, alu_sign} = ~fl;
      for (int i = 0; i < 8; i++) begin
        go_exec(3'd3, 3'(i), 1'b1);
        checks++;
        if ({pc_we, pc_sel, rf_we} !== {1'b1, tk[i], 1'b0}) begin
          errors++; $display("FAIL branch cond=%0d flags=%b pc_we/sel/rf=%b exp 1%b0",
                            i, flags, {pc_we, pc_sel, rf_we}, tk[i]);
        end
        nxt(); exp_cnt = exp_cnt + 16'd1;
      end
      checks++;
      if ({flags, instr_count} !== {fl, exp_cnt}) begin
        errors++; $display("FAIL branch_flags flags=%b cnt=%0d exp %b/%0d", flags, instr_count, fl, exp_cnt);
      end
    end
    go_exec(3'd4, 3'd7, 1'b0);
    checks++;
    if ({pc_we, pc_sel} !== 2'b11) begin
      errors++; $display("FAIL jump pc_we/sel=%b exp 11", {pc_we, pc_sel});
    end
    nxt(); exp_cnt = exp_cnt + 16'd1;
    go_exec(3'd5, 3'd0, 1'b0);
    checks++;
    if ({pc_we, pc_sel, rf_we} !== 3'b100) begin
      errors++; $display("FAIL reserved pc_we/sel/rf=%b exp 100", {pc_we, pc_sel, rf_we});
    end
    nxt(); exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_flag_order();
    {alu_carry, alu_zero, alu_sign} = 3'b010;
    go_exec(3'd0, 3'd0, 1'b1);
    nxt(); exp_cnt = exp_cnt + 16'd1;
    go_exec(3'd3, 3'd1, 1'b0);
    checks++;
    if (pc_sel !== 1'b1) begin errors++; $display("FAIL order_bz_after_alu pc_sel=%b exp 1", pc_sel); end
    nxt(); exp_cnt = exp_cnt + 16'd1;
    {alu_carry, alu_zero, alu_sign} = 3'b000;
    go_exec(3'd0, 3'd0, 1'b1);
    nxt(); exp_cnt = exp_cnt + 16'd1;
    {alu_carry, alu_zero, alu_sign} = 3'b010;
    go_exec(3'd1, 3'd0, 1'b1);
    checks++;
    if ({pc_we, rf_we, mem_req} !== 3'b000) begin
      errors++; $display("FAIL load_exec en=%b exp 000", {pc_we, rf_we, mem_req});
    end
    nxt();
    checks++;
    if ({state, mem_req, rf_we, pc_we} !== {3'd4, 3'b111}) begin
      errors++; $display("FAIL load_mem0 state=%0d req/rf/pc=%b exp 4/111", state, {mem_req, rf_we, pc_we});
    end
    nxt(); exp_cnt = exp_cnt + 16'd1;
    go_exec(3'd3, 3'd1, 1'b0);
    checks++;
    if ({flags, pc_sel} !== {3'b000, 1'b0}) begin
      errors++; $display("FAIL order_bz_after_load flags=%b pc_sel=%b exp 000/0", flags, pc_sel);
    end
    nxt(); exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_mem_wait();
    go_exec(3'd1, 3'd0, 1'b0);
    nxt();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({state, mem_req, rf_we, pc_we} !== {3'd4, 3'b100}) begin
        errors++; $display("FAIL load_wait%0d state=%0d req/rf/pc=%b exp 4/100", i, state, {mem_req, rf_we, pc_we});
      end
      nxt();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({mem_req, rf_we, pc_we, pc_sel, mem_we} !== 5'b11100) begin
      errors++; $display("FAIL load_ready got=%b exp 11100", {mem_req, rf_we, pc_we, pc_sel, mem_we});
    end
    nxt(); exp_cnt = exp_cnt + 16'd1;
    go_exec(3'd2, 3'd0, 1'b0);
    nxt();
    checks++;
    if ({state, mem_req, mem_we, rf_we, pc_we} !== {3'd4, 4'b1101}) begin
      errors++; $display("FAIL store_mem state=%0d req/we/rf/pc=%b exp 4/1101",
                        state, {mem_req, mem_we, rf_we, pc_we});
    end
    nxt(); exp_cnt = exp_cnt + 16'd1;
    checks++;
    if ({state, instr_count} !== {3'd1, exp_cnt}) begin
      errors++; $display("FAIL store_after state=%0d cnt=%0d exp 1/%0d", state, instr_count, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_ready = 1'b0;
    start_run();
    for (int i = 1; i <= 15; i++) begin
      checks++;
      if ({state, mem_req, fault} !== {3'd1, 2'b10}) begin
        errors++; $display("FAIL timeout_wait%0d state=%0d req=%b fault=%b exp 1/1/0", i, state, mem_req, fault);
      end
      nxt();
    end
    checks++;
    if ({state, fault, mem_req} !== {3'd6, 2'b10}) begin
      errors++; $display("FAIL timeout_fault state=%0d fault=%b req=%b exp 6/1/0", state, fault, mem_req);
    end
    start = 1'b1; mem_ready = 1'b1;
    #1;
    nxt(); nxt();
    start = 1'b0;
    checks++;
    if ({state, ir_we, mem_req} !== {3'd6, 2'b00}) begin
      errors++; $display("FAIL fault_sticky state=%0d ir/req=%b exp 6/00", state, {ir_we, mem_req});
    end
    do_reset();
    mem_ready = 1'b0;
    start_run();
    repeat (14) nxt();
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({state, ir_we} !== {3'd1, 1'b1}) begin
      errors++; $display("FAIL ready_at_limit state=%0d ir_we=%b exp 1/1", state, ir_we);
    end
    nxt();
    checks++;
    if ({state, fault} !== {3'd2, 1'b0}) begin
      errors++; $display("FAIL no_fault state=%0d fault=%b exp 2/0", state, fault);
    end
  endtask

  task automatic test_halt();
    do_reset();
    start_run();
    go_exec(3'd0, 3'd0, 1'b0);
    nxt(); exp_cnt = 16'd1;
    go_exec(3'd7, 3'd0, 1'b0);
    checks++;
    if ({state, pc_we} !== {3'd3, 1'b0}) begin
      errors++; $display("FAIL halt_exec state=%0d pc_we=%b exp 3/0", state, pc_we);
    end
    nxt(); exp_cnt = 16'd2;
    checks++;
    if ({state, halted, instr_count} !== {3'd5, 1'b1, exp_cnt}) begin
      errors++; $display("FAIL halt_entry state=%0d halted=%b cnt=%0d exp 5/1/2", state, halted, instr_count);
    end
    start = 1'b1;
    #1;
    repeat (3) nxt();
    start = 1'b0;
    checks++;
    if ({state, instr_count, ir_we, pc_we, mem_req} !== {3'd5, exp_cnt, 3'b000}) begin
      errors++; $display("FAIL halt_sticky state=%0d cnt=%0d en=%b exp 5/2/000",
                        state, instr_count, {ir_we, pc_we, mem_req});
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    start_run();
    {alu_carry, alu_zero, alu_sign} = 3'b101;
    go_exec(3'd0, 3'd0, 1'b1);
    nxt();
    go_exec(3'd1, 3'd0, 1'b0);
    nxt();
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({state, mem_req, flags} !== {3'd4, 1'b1, 3'b101}) begin
      errors++; $display("FAIL pre_rst state=%0d req=%b flags=%b exp 4/1/101", state, mem_req, flags);
    end
    rst = 1'b1;
    #1;
    nxt();
    checks++;
    if ({state, flags, instr_count, ir_we, pc_we, pc_sel, rf_we, mem_req, mem_we, halted, fault} !== 30'd0) begin
      errors++; $display("FAIL rst_mid_mem state=%0d flags=%b cnt=%0d en=%b exp all 0", state, flags,
                        instr_count, {ir_we, pc_we, pc_sel, rf_we, mem_req, mem_we, halted, fault});
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; op_class = 3'd0; br_cond = 3'd0; set_flags = 1'b0;
    alu_carry = 1'b0; alu_zero = 1'b0; alu_sign = 1'b0; mem_ready = 1'b0;
    exp_cnt = 16'd0;
    test_reset();
    test_alu();
    test_branch();
    test_flag_order();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
